// File: rtl/awgn_rx_pkg.sv
// awgn_rx_pkg: shared types and default tuning constants for the AWGN receive filter.
package awgn_rx_pkg;
   localparam int          DEF_WIDTH      = 16;
   localparam int          DEF_LOG2_WIN   = 3;
   localparam logic [15:0] DEF_BAD_THRESH = 16'h0400;
   localparam int          DEF_ENTER_CNT  = 4;
   localparam int          DEF_EXIT_CNT   = 8;
   localparam int          LANES          = 4;
   typedef enum logic {GOOD, BAD} chan_state_t;
   typedef logic signed [15:0] sample_t;
endpackage

// File: rtl/awgn_rx_filter_if.sv
// awgn_rx_filter_if: beat handshake and sample lanes; bad_beats exists only with RX_STATS_EN.
interface awgn_rx_filter_if #(parameter int WIDTH = 16);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in1;
   logic [WIDTH-1:0] data_in2;
   logic [WIDTH-1:0] data_in3;
   logic [WIDTH-1:0] data_in4;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out1;
   logic [WIDTH-1:0] data_out2;
   logic [WIDTH-1:0] data_out3;
   logic [WIDTH-1:0] data_out4;
   logic             chan_bad;
   logic [WIDTH-1:0] residual;
`ifdef RX_STATS_EN
   logic [15:0]      bad_beats;
`endif
   modport master (
      output in_valid, data_in1, data_in2, data_in3, data_in4, out_ready,
      input  in_ready, out_valid, data_out1, data_out2, data_out3, data_out4, chan_bad, residual
`ifdef RX_STATS_EN
      , input bad_beats
`endif
   );
   modport slave (
      input  in_valid, data_in1, data_in2, data_in3, data_in4, out_ready,
      output in_ready, out_valid, data_out1, data_out2, data_out3, data_out4, chan_bad, residual
`ifdef RX_STATS_EN
      , output bad_beats
`endif
   );
endinterface

// File: rtl/awgn_rx_mavg.sv
// awgn_rx_mavg: one-lane moving average; history, running sum and next shifted average.
module awgn_rx_mavg #(
   parameter int WIDTH    = 16,
   parameter int LOG2_WIN = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    acc_i,
   input  logic [LOG2_WIN-1:0]     wp_i,
   input  logic signed [WIDTH-1:0] x_i,
   output logic signed [WIDTH-1:0] avg_o
);
   localparam int SW    = WIDTH + LOG2_WIN;
   localparam int DEPTH = 1 << LOG2_WIN;
   logic signed [WIDTH-1:0] hist_q [DEPTH];
   logic signed [SW-1:0]    sum_q;
   logic signed [SW-1:0]    sum_d;
   assign sum_d = sum_q + SW'(x_i) - SW'(hist_q[wp_i]);
   assign avg_o = WIDTH'(sum_d >>> LOG2_WIN);
   always_ff @(posedge clk) begin
      if (!reset) begin
         sum_q <= '0;
         for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      end else if (acc_i) begin
         sum_q        <= sum_d;
         hist_q[wp_i] <= x_i;
      end
   end
endmodule

// File: rtl/awgn_rx_filter.sv
// awgn_rx_filter: four-lane moving-average filter with hysteresis channel-quality estimate.
// Define RX_STATS_EN to add the saturating bad_beats counter.
module awgn_rx_filter
   import awgn_rx_pkg::*;
#(
   parameter int               WIDTH      = DEF_WIDTH,
   parameter int               LOG2_WIN   = DEF_LOG2_WIN,
   parameter logic [WIDTH-1:0] BAD_THRESH = WIDTH'(DEF_BAD_THRESH),
   parameter int               ENTER_CNT  = DEF_ENTER_CNT,
   parameter int               EXIT_CNT   = DEF_EXIT_CNT
) (
   input logic             clk,
   input logic             reset,
   awgn_rx_filter_if.slave bus
);
   localparam int CNT_W = $clog2((ENTER_CNT > EXIT_CNT ? ENTER_CNT : EXIT_CNT) + 1);
   logic                    acc;
   logic [LOG2_WIN-1:0]     wp_q;
   logic signed [WIDTH-1:0] x      [LANES];
   logic signed [WIDTH-1:0] avg_d  [LANES];
   logic signed [WIDTH-1:0] dout_q [LANES];
   logic                    out_valid_q;
   logic signed [WIDTH:0]   diff;
   logic [WIDTH:0]          mag;
   logic [WIDTH-1:0]        res_d;
   logic [WIDTH-1:0]        res_q;
   logic                    noisy;
   chan_state_t             state_q;
   chan_state_t             state_d;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic [CNT_W-1:0]        cnt_inc;
   logic [CNT_W-1:0]        lim;
   logic                    hit;
   logic                    chan_bad_q;
   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign acc          = bus.in_valid && bus.in_ready;
   assign x            = '{bus.data_in1, bus.data_in2, bus.data_in3, bus.data_in4};
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      awgn_rx_mavg #(.WIDTH(WIDTH), .LOG2_WIN(LOG2_WIN)) u_mavg (
         .clk   (clk),
         .reset (reset),
         .acc_i (acc),
         .wp_i  (wp_q),
         .x_i   (x[l]),
         .avg_o (avg_d[l])
      );
   end
   // dout_q[0] always equals lane-1 sum >>> LOG2_WIN from before this beat
   always_comb begin
      diff    = (WIDTH+1)'(x[0]) - (WIDTH+1)'(dout_q[0]);
      mag     = diff[WIDTH] ? -diff : diff;
      res_d   = mag[WIDTH] ? '1 : mag[WIDTH-1:0];
      noisy   = res_d > BAD_THRESH;
      cnt_inc = cnt_q + CNT_W'(1);
      hit     = state_q == GOOD ? noisy : !noisy;
      lim     = state_q == GOOD ? CNT_W'(ENTER_CNT) : CNT_W'(EXIT_CNT);
      cnt_d   = (!hit || cnt_inc == lim) ? '0 : cnt_inc;
      state_d = (hit && cnt_inc == lim) ? (state_q == GOOD ? BAD : GOOD) : state_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         wp_q        <= '0;
         res_q       <= '0;
         dout_q      <= '{default: '0};
      end else if (bus.in_ready) begin
         out_valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            wp_q   <= wp_q + LOG2_WIN'(1);
            res_q  <= res_d;
            dout_q <= avg_d;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= GOOD;
         cnt_q      <= '0;
         chan_bad_q <= 1'b0;
      end else if (acc) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         chan_bad_q <= state_d == BAD;
      end
   end
   assign bus.out_valid = out_valid_q;
   assign bus.data_out1 = dout_q[0];
   assign bus.data_out2 = dout_q[1];
   assign bus.data_out3 = dout_q[2];
   assign bus.data_out4 = dout_q[3];
   assign bus.residual  = res_q;
   assign bus.chan_bad  = chan_bad_q;
`ifdef RX_STATS_EN
   logic [15:0] bad_beats_q;
   always_ff @(posedge clk) begin
      if (!reset) bad_beats_q <= '0;
      else if (acc && state_q == BAD && bad_beats_q != 16'hFFFF) bad_beats_q <= bad_beats_q + 16'd1;
   end
   assign bus.bad_beats = bad_beats_q;
`endif
endmodule

// File: tb/tb_awgn_rx_filter.sv
// tb_awgn_rx_filter: scoreboard bench for awgn_rx_filter against an integer reference model.
module tb_awgn_rx_filter;
   import awgn_rx_pkg::*;
   typedef struct packed {
      logic [3:0][15:0] d;
      logic [15:0]      res;
      logic             bad;
      logic [15:0]      bb;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int checks = 0;
   int failures = 0;
   awgn_rx_filter_if bus ();
   awgn_rx_filter dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int   hist [4][8];
   int   sum  [4];
   int   wp, cnt, bb, pushes, pops;
   bit   m_bad, ov;
   exp_t sb [$];
   logic [15:0] got_d1 [$];
   logic [15:0] got_res [$];
   logic        got_bad [$];
   logic [15:0] got_bb [$];
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      foreach (hist[l, i]) hist[l][i] = 0;
      foreach (sum[l]) sum[l] = 0;
      wp = 0; cnt = 0; bb = 0; m_bad = 0; ov = 0;
      sb.delete();
   endtask
   task automatic model_accept(input logic [15:0] a, b, c, e4);
      exp_t e;
      int   xs [4];
      int   d, old;
      bit   noisy;
      xs = '{int'(sample_t'(a)), int'(sample_t'(b)), int'(sample_t'(c)), int'(sample_t'(e4))};
      d = xs[0] - (sum[0] >>> 3);
      if (d < 0) d = -d;
      if (d > 65535) d = 65535;
      e.res = d[15:0];
      if (m_bad && bb < 65535) bb++;
      for (int l = 0; l < 4; l++) begin
         old = hist[l][wp];
         sum[l] = sum[l] + xs[l] - old;
         hist[l][wp] = xs[l];
         d = sum[l] >>> 3;
         e.d[l] = d[15:0];
      end
      wp = (wp + 1) % 8;
      noisy = e.res > 16'h0400;
      if (!m_bad) begin
         cnt = noisy ? cnt + 1 : 0;
         if (cnt == 4) begin m_bad = 1; cnt = 0; end
      end else begin
         cnt = noisy ? 0 : cnt + 1;
         if (cnt == 8) begin m_bad = 0; cnt = 0; end
      end
      e.bad = m_bad;
      e.bb = bb[15:0];
      sb.push_back(e);
      pushes++;
   endtask
   task automatic step(input bit v, input bit r, input logic [15:0] a, b, c, e4);
      exp_t e;
      @(negedge clk);
      bus.in_valid = v; bus.out_ready = r;
      bus.data_in1 = a; bus.data_in2 = b; bus.data_in3 = c; bus.data_in4 = e4;
      #1;
      check("in_ready", bus.in_ready, !ov || r);
      check("out_valid", bus.out_valid, ov);
      if (ov && bus.out_valid) begin
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb[0];
            check("data_out1", bus.data_out1, e.d[0]);
            check("data_out2", bus.data_out2, e.d[1]);
            check("data_out3", bus.data_out3, e.d[2]);
            check("data_out4", bus.data_out4, e.d[3]);
            check("residual", bus.residual, e.res);
            check("chan_bad", bus.chan_bad, e.bad);
`ifdef RX_STATS_EN
            check("bad_beats", bus.bad_beats, e.bb);
`endif
            if (r) begin
               void'(sb.pop_front());
               pops++;
               got_d1.push_back(bus.data_out1);
               got_res.push_back(bus.residual);
               got_bad.push_back(bus.chan_bad);
`ifdef RX_STATS_EN
               got_bb.push_back(bus.bad_beats);
`endif
            end
         end
      end
      if (v && (!ov || r)) model_accept(a, b, c, e4);
      ov = (!ov || r) ? v : 1'b1;
   endtask
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      model_reset();
      @(negedge clk);
      #1;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_data_out1", bus.data_out1, 0);
      check("rst_data_out2", bus.data_out2, 0);
      check("rst_data_out3", bus.data_out3, 0);
      check("rst_data_out4", bus.data_out4, 0);
      check("rst_residual", bus.residual, 0);
      check("rst_chan_bad", bus.chan_bad, 0);
`ifdef RX_STATS_EN
      check("rst_bad_beats", bus.bad_beats, 0);
`endif
      reset = 1'b1;
      got_d1.delete(); got_res.delete(); got_bad.delete(); got_bb.delete();
   endtask
   initial begin
      bus.in_valid = 0; bus.out_ready = 0;
      bus.data_in1 = 0; bus.data_in2 = 0; bus.data_in3 = 0; bus.data_in4 = 0;
      model_reset();
      do_reset();
      // constant positive input: ramp then settle
      for (int i = 0; i < 10; i++) step(1, 1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      step(0, 1, 0, 0, 0, 0);
      check("pos_len", got_d1.size(), 10);
      check("pos_beat1", got_d1[0], 16'h0020);
      check("pos_beat2", got_d1[1], 16'h0040);
      for (int i = 7; i < 10; i++) check("pos_settled", got_d1[i], 16'h0100);
      for (int i = 0; i < 10; i++) check("pos_good", got_bad[i], 0);
      do_reset();
      // constant negative input
      for (int i = 0; i < 10; i++) step(1, 1, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
      step(0, 1, 0, 0, 0, 0);
      check("neg_beat1", got_d1[0], 16'hFFE0);
      for (int i = 7; i < 10; i++) check("neg_settled", got_d1[i], 16'hFF00);
      do_reset();
      // lane-1 spike drives the channel BAD, then quiet brings it back
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 16'h2000, 0, 0, 0);
      for (int i = 0; i < 16; i++) step(1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check("spk_len", got_res.size(), 40);
      check("spk_res1", got_res[20], 16'h2000);
      check("spk_res2", got_res[21], 16'h1C00);
      check("spk_res3", got_res[22], 16'h1800);
      check("spk_res4", got_res[23], 16'h1400);
      check("spk_bad3", got_bad[22], 0);
      check("spk_bad4", got_bad[23], 1);
      check("spk_bad_mid", got_bad[30], 1);
      check("spk_bad_7q", got_bad[37], 1);
      check("spk_good_8q", got_bad[38], 0);
      // backpressure with random data and idle gaps
      pushes = 0; pops = 0;
      for (int i = 0; i < 6; i++) step(1, 1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         check("bp_in_ready", bus.in_ready, 0);
      end
      for (int i = 0; i < 12; i++)
         step(i % 4 != 3, 1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      step(0, 1, 0, 0, 0, 0);
      check("bp_no_loss", pops, pushes);
      // reset mid-stream while BAD
      for (int i = 0; i < 6; i++) step(1, 1, i % 2 ? 16'h9000 : 16'h7000, 0, 0, 0);
      check("pre_rst_bad", bus.chan_bad, 1);
      do_reset();
      step(1, 1, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
      step(0, 1, 0, 0, 0, 0);
      check("post_rst_beat1", got_d1[0], 16'h0020);
      check("post_rst_good", got_bad[0], 0);
`ifdef RX_STATS_EN
      do_reset();
      for (int i = 0; i < 14; i++) step(1, 1, i % 2 ? 16'h9000 : 16'h7000, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check("stats_10", got_bb[13], 10);
      for (int i = 0; i < 70000; i++) step(1, 1, i % 2 ? 16'h7000 : 16'h9000, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check("stats_sat", bus.bad_beats, 16'hFFFF);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
